// File: rtl/instruction_cycle_sequencer.sv
// Multi-cycle instruction sequencer for the ARMAria datapath.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
// It stalls in IO_WAIT for the operator buttons and in HALT for a halt instruction.
// Build option: define SINGLE_STEP_EN to let single_step park the core in HALT after every WRITEBACK.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset, all strobes low
// FETCH     | load instruction register
// DECODE    | control unit decodes; halt_request checked here
// EXECUTE   | ALU / flag update, choose IO_WAIT, MEMORY or WRITEBACK
// MEMORY    | memory access, MEM_LATENCY cycles, write pulse on the last one
// WRITEBACK | regfile write, PC advance, instruction retired
// IO_WAIT   | stalled for confirmation (input) or continue (output)
// HALT      | stopped until continue_button

// Two-flop synchroniser with rising-edge detect for an asynchronous button.
module button_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Shift the button through two metastability flops plus one delay flop for edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // A held button gives a single one-cycle pulse.
  assign rise = sync2 & ~sync2_d;

endmodule

module instruction_cycle_sequencer #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   is_input,
  input  logic                   is_output,
  input  logic                   is_memory_op,
  input  logic                   allow_write_on_memory,
  input  logic                   halt_request,
  input  logic                   confirmation,
  input  logic                   continue_button,
  input  logic                   single_step,
  output logic                   instruction_load,
  output logic                   enable,
  output logic                   mem_write_strobe,
  output logic                   regfile_write,
  output logic                   pc_enable,
  output logic                   waiting_io,
  output logic                   halted,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    IO_WAIT   = 3'd6,
    HALT      = 3'd7
  } state_t;

  // The counter starts at MEM_LATENCY-1, so the last MEMORY cycle is the one where it reads 0.
  localparam logic [3:0] MEM_LOAD = 4'(MEM_LATENCY - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] mem_count;
  logic       mem_last;
  logic       io_input_mode;
  logic       confirm_rise;
  logic       continue_rise;

  button_edge_sync u_confirm_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (confirmation),
    .rise     (confirm_rise)
  );

  button_edge_sync u_continue_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (continue_button),
    .rise     (continue_rise)
  );

`ifndef SINGLE_STEP_EN
  logic unused_single_step;
  assign unused_single_step = single_step;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MEMORY latency down-counter, loaded on the EXECUTE->MEMORY transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_count <= 4'd0;
    end else if (state_q == EXECUTE && state_d == MEMORY) begin
      mem_count <= MEM_LOAD;
    end else if (state_q == MEMORY && !mem_last) begin
      mem_count <= mem_count - 4'd1;
    end
  end

  assign mem_last = (mem_count == 4'd0);

  // Latch which button releases IO_WAIT; decode inputs may change while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_input_mode <= 1'b0;
    end else if (state_q == EXECUTE && state_d == IO_WAIT) begin
      io_input_mode <= is_input;
    end
  end

  // Count instructions as they leave WRITEBACK; wraps naturally at the top.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (state_q == WRITEBACK) begin
      retired_count <= retired_count + COUNT_WIDTH'(1);
    end
  end

  // Next-state logic and the per-state output decode.
  always_comb begin
    state_d          = state_q;
    instruction_load = 1'b0;
    enable           = 1'b0;
    mem_write_strobe = 1'b0;
    regfile_write    = 1'b0;
    pc_enable        = 1'b0;
    waiting_io       = 1'b0;
    halted           = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        instruction_load = 1'b1;
        state_d          = DECODE;
      end
      DECODE: begin
        state_d = halt_request ? HALT : EXECUTE;
      end
      EXECUTE: begin
        enable = 1'b1;
        if (is_input || is_output) begin
          state_d = IO_WAIT;
        end else if (is_memory_op) begin
          state_d = MEMORY;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        if (mem_last) begin
          mem_write_strobe = allow_write_on_memory;
          state_d          = WRITEBACK;
        end
      end
      WRITEBACK: begin
        regfile_write = 1'b1;
        pc_enable     = 1'b1;
        state_d       = FETCH;
`ifdef SINGLE_STEP_EN
        if (single_step) begin
          state_d = HALT;
        end
`endif
      end
      IO_WAIT: begin
        waiting_io = 1'b1;
        if (io_input_mode ? confirm_rise : continue_rise) begin
          state_d = WRITEBACK;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (continue_rise) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule
